// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a one-entry skid buffer and immediate-format pre-decode.
// The skid absorbs the single fetch already in flight when decode stalls.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_f,
  input  logic [31:0] inst_f,
  input  logic        valid_f,
  input  logic        stall_d,
  input  logic        flush_d,
  output logic        fetch_ready,
  output logic [31:0] pc_d,
  output logic [31:0] inst_d,
  output logic        valid_d,
  output logic [24:0] imm_inst,
  output logic [2:0]  ImmSel,
  output logic [4:0]  rs1_d,
  output logic [4:0]  rs2_d,
  output logic [4:0]  rd_d
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} skid_state_e;

  localparam logic [2:0] IMM_NONE_BUBBLE = 3'h1;

  skid_state_e state_q, state_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic [2:0]  imm_sel_q, imm_sel_d;

  function automatic logic [2:0] imm_sel_of(input logic [6:0] opc, input logic [2:0] f3);
    logic [2:0] sel;
    sel = 3'h7;
    case (opc)
      7'b0010011: sel = (f3 == 3'b001 || f3 == 3'b101) ? 3'h0 : 3'h1;
      7'b0000011,
      7'b1100111: sel = 3'h1;
      7'b0100011: sel = 3'h2;
      7'b1100011: sel = 3'h3;
      7'b1101111: sel = 3'h4;
      7'b0110111,
      7'b0010111: sel = 3'h5;
      default:    sel = 3'h7;
    endcase
    return sel;
  endfunction

  always_comb begin
    state_d     = state_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    id_pc_d     = id_pc_q;
    id_inst_d   = id_inst_q;
    id_valid_d  = id_valid_q;
    imm_sel_d   = imm_sel_q;
    if (flush_d) begin
      // Wrong-path fetch this cycle is dropped along with the skid.
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
      imm_sel_d  = IMM_NONE_BUBBLE;
      state_d    = EMPTY;
    end else if (stall_d) begin
      if (state_q == EMPTY && valid_f) begin
        skid_pc_d   = pc_f;
        skid_inst_d = inst_f;
        state_d     = FULL;
      end
    end else if (state_q == FULL) begin
      id_pc_d    = skid_pc_q;
      id_inst_d  = skid_inst_q;
      id_valid_d = 1'b1;
      imm_sel_d  = imm_sel_of(skid_inst_q[6:0], skid_inst_q[14:12]);
      if (valid_f) begin
        skid_pc_d   = pc_f;
        skid_inst_d = inst_f;
      end else begin
        state_d = EMPTY;
      end
    end else if (valid_f) begin
      id_pc_d    = pc_f;
      id_inst_d  = inst_f;
      id_valid_d = 1'b1;
      imm_sel_d  = imm_sel_of(inst_f[6:0], inst_f[14:12]);
    end else begin
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
      imm_sel_d  = IMM_NONE_BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
      id_pc_q     <= RESET_PC;
      id_inst_q   <= NOP_INST;
      id_valid_q  <= 1'b0;
      imm_sel_q   <= IMM_NONE_BUBBLE;
    end else begin
      state_q     <= state_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      id_valid_q  <= id_valid_d;
      imm_sel_q   <= imm_sel_d;
    end
  end

  assign fetch_ready = (state_q == EMPTY);
  assign pc_d        = id_pc_q;
  assign inst_d      = id_inst_q;
  assign valid_d     = id_valid_q;
  assign ImmSel      = imm_sel_q;
  assign imm_inst    = id_inst_q[31:7];
  assign rs1_d       = id_inst_q[19:15];
  assign rs2_d       = id_inst_q[24:20];
  assign rd_d        = id_inst_q[11:7];

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: each scenario task drives vectors and checks
// the packed ID-side outputs against hand-computed values.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset, valid_f, stall_d, flush_d;
  logic [31:0] pc_f, inst_f;
  logic        fetch_ready, valid_d;
  logic [31:0] pc_d, inst_d;
  logic [24:0] imm_inst;
  logic [2:0]  ImmSel;
  logic [4:0]  rs1_d, rs2_d, rd_d;

  int n_cmp = 0;
  int n_bad = 0;

  // {valid_d, ImmSel, inst_d, pc_d, fetch_ready}
  logic [68:0] obs, exp;
  assign obs = {valid_d, ImmSel, inst_d, pc_d, fetch_ready};

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_id_stage dut (
    .clk(clk), .reset(reset), .pc_f(pc_f), .inst_f(inst_f), .valid_f(valid_f),
    .stall_d(stall_d), .flush_d(flush_d), .fetch_ready(fetch_ready),
    .pc_d(pc_d), .inst_d(inst_d), .valid_d(valid_d), .imm_inst(imm_inst),
    .ImmSel(ImmSel), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic st, input logic fl);
    valid_f = v; pc_f = pc; inst_f = inst; stall_d = st; flush_d = fl;
  endtask

  task automatic test_reset();
    reset = 1'b1; drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(); step();
    reset = 1'b0;
    step();
    exp = {1'b0, 3'h1, NOP, 32'h0100_0000, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL reset_state got %h exp %h", obs, exp); end
  endtask

  task automatic test_stream();
    logic [31:0] insts [5];
    insts = '{32'h00500093, 32'h00112023, 32'h00208463, 32'h008000EF, 32'h12345137};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), insts[i], 1'b0, 1'b0);
      step();
      exp = {1'b1, 3'(i + 1), insts[i], 32'h1000 + 32'(4 * i), 1'b1};
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL stream_%0d got %h exp %h", i, obs, exp); end
    end
    drive(1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    step();
    exp = {1'b0, 3'h1, NOP, 32'h0000_1010, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL bubble got %h exp %h", obs, exp); end
  endtask

  task automatic test_shamt_rtype();
    drive(1'b1, 32'h2000, 32'h00309093, 1'b0, 1'b0);
    step();
    exp = {1'b1, 3'h0, 32'h00309093, 32'h2000, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL slli got %h exp %h", obs, exp); end
    drive(1'b1, 32'h2004, 32'h002081B3, 1'b0, 1'b0);
    step();
    exp = {1'b1, 3'h7, 32'h002081B3, 32'h2004, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL add got %h exp %h", obs, exp); end
    n_cmp++;
    if ({imm_inst, rs1_d, rs2_d, rd_d} !== {25'h0004103, 5'd1, 5'd2, 5'd3}) begin
      n_bad++;
      $display("FAIL fields got %h/%0d/%0d/%0d exp 4103/1/2/3", imm_inst, rs1_d, rs2_d, rd_d);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h3000, 32'h00500093, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h3004, 32'h00112023, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      exp = {1'b1, 3'h1, 32'h00500093, 32'h3000, 1'b0};
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL stall_hold_%0d got %h exp %h", i, obs, exp); end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    exp = {1'b1, 3'h2, 32'h00112023, 32'h3004, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL stall_release got %h exp %h", obs, exp); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h4000, 32'h12345137, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h4004, 32'h00208463, 1'b1, 1'b0);
    step();
    // Protocol violation while full: this fetch must vanish.
    drive(1'b1, 32'h4444, 32'h00309093, 1'b1, 1'b0);
    step();
    exp = {1'b1, 3'h5, 32'h12345137, 32'h4000, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL b2b_hold got %h exp %h", obs, exp); end
    drive(1'b1, 32'h4008, 32'h008000EF, 1'b0, 1'b0);
    step();
    exp = {1'b1, 3'h3, 32'h00208463, 32'h4004, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL b2b_first got %h exp %h", obs, exp); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    exp = {1'b1, 3'h4, 32'h008000EF, 32'h4008, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL b2b_second got %h exp %h", obs, exp); end
    step();
    exp = {1'b0, 3'h1, NOP, 32'h4008, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL b2b_drained got %h exp %h", obs, exp); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h5000, 32'h00500093, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h5004, 32'h00112023, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h5008, 32'h00208463, 1'b1, 1'b1);
    step();
    exp = {1'b0, 3'h1, NOP, 32'h5000, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL flush got %h exp %h", obs, exp); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL flush_skid_clear got %h exp %h", obs, exp); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 32'h6000, 32'h00500093, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h6004, 32'h00112023, 1'b1, 1'b0);
    step();
    reset = 1'b1;
    drive(1'b1, 32'h6008, 32'h00208463, 1'b1, 1'b0);
    step();
    exp = {1'b0, 3'h1, NOP, 32'h0100_0000, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL reset_mid_stall got %h exp %h", obs, exp); end
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL reset_skid_clear got %h exp %h", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_shamt_rtype();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
